// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch path: opcode fields, pc_sel encodings,
// fetch FSM states and the PC register operations.
package isa_pkg;

  localparam logic [4:0] OPC_NOP = 5'b00000;
  localparam logic [4:0] OPC_LDM = 5'b10011;
  localparam logic [4:0] OPC_INT = 5'b11111;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_JMP = 2'b01;
  localparam logic [1:0] PCSEL_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_VEC_HI = 2'd0,
    ST_VEC_LO = 2'd1,
    ST_RUN    = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    PC_HOLD  = 3'd0,
    PC_LOAD  = 3'd1,
    PC_INC   = 3'd2,
    PC_LD_HI = 3'd3,
    PC_LD_LO = 3'd4
  } pc_op_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: hold, full load, increment (wraps) and the high/low
// half loads used while a vector is being read from instruction memory.
module pc_reg
  import isa_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  pc_op_e              op_i,
  input  logic [PC_WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0]    half_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    case (op_i)
      PC_LOAD:  pc_d = load_val_i;
      PC_INC:   pc_d = pc_q + PC_WIDTH'(1);
      PC_LD_HI: pc_d[PC_WIDTH-1 -: WIDTH] = half_i;
      PC_LD_LO: pc_d[WIDTH-1:0] = half_i;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: vector loading FSM, LDM immediate tagging,
// interrupt injection and the IF/ID pipeline register.
module fetch_unit
  import isa_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned RST_VEC_ADDR = 0,
  parameter int unsigned INT_VEC_ADDR = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0]    imem_data,
  input  logic                stall,
  input  logic                flush,
  input  logic                fetch_pc_enable,
  input  logic [1:0]          pc_sel,
  input  logic [PC_WIDTH-1:0] pc_jmp,
  input  logic [PC_WIDTH-1:0] pc_mem,
  input  logic                interrupt,
  output logic [WIDTH-1:0]    instruction,
  output logic                ldm_value,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic                int_ack
);

  localparam logic [PC_WIDTH-1:0] RST_VEC  = PC_WIDTH'(RST_VEC_ADDR);
  localparam logic [PC_WIDTH-1:0] INT_VEC  = PC_WIDTH'(INT_VEC_ADDR);
  localparam logic [WIDTH-1:0]    INT_WORD = {OPC_INT, {(WIDTH-5){1'b0}}};

  fetch_state_e        state_q, state_d;
  logic                vec_int_q, vec_int_d;
  logic                ldm_pending_q, ldm_pending_d;
  logic                int_pending_q, int_pending_d;
  logic [WIDTH-1:0]    instr_q, instr_d;
  logic                ldm_q, ldm_d;
  logic [PC_WIDTH-1:0] pcp1_q, pcp1_d;
  logic                int_ack_q, int_ack_d;

  logic [PC_WIDTH-1:0] pc, vec_base, redir_val;
  pc_op_e              pc_op, redir_op;

  pc_reg #(
    .WIDTH   (WIDTH),
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .op_i      (pc_op),
    .load_val_i(redir_val),
    .half_i    (imem_data),
    .pc_o      (pc)
  );

  assign vec_base = vec_int_q ? INT_VEC : RST_VEC;

  always_comb begin
    case (state_q)
      ST_VEC_HI: imem_addr = vec_base;
      ST_VEC_LO: imem_addr = vec_base + PC_WIDTH'(1);
      default:   imem_addr = pc;
    endcase
  end

  always_comb begin
    redir_op  = PC_INC;
    redir_val = pc_jmp;
    if (pc_sel == PCSEL_JMP) begin
      redir_op  = PC_LOAD;
      redir_val = pc_jmp;
    end else if (pc_sel == PCSEL_MEM) begin
      redir_op  = PC_LOAD;
      redir_val = pc_mem;
    end
  end

  always_comb begin
    state_d       = state_q;
    vec_int_d     = vec_int_q;
    ldm_pending_d = ldm_pending_q;
    int_pending_d = int_pending_q | interrupt;
    instr_d       = instr_q;
    ldm_d         = ldm_q;
    pcp1_d        = pcp1_q;
    int_ack_d     = 1'b0;
    pc_op         = PC_HOLD;

    if (flush) begin
      instr_d       = '0;
      ldm_d         = 1'b0;
      ldm_pending_d = 1'b0;
      // A flush during vector loading must not corrupt the half loads.
      if (state_q == ST_RUN)        pc_op = redir_op;
      else if (state_q == ST_VEC_HI) begin
        pc_op   = PC_LD_HI;
        state_d = ST_VEC_LO;
      end else begin
        pc_op   = PC_LD_LO;
        state_d = ST_RUN;
      end
    end else if (stall) begin
      pc_op = PC_HOLD;
    end else if (!fetch_pc_enable) begin
      instr_d = '0;
      ldm_d   = 1'b0;
    end else if (state_q == ST_VEC_HI) begin
      instr_d = '0;
      ldm_d   = 1'b0;
      pc_op   = PC_LD_HI;
      state_d = ST_VEC_LO;
    end else if (state_q == ST_VEC_LO) begin
      instr_d = '0;
      ldm_d   = 1'b0;
      pc_op   = PC_LD_LO;
      state_d = ST_RUN;
    end else if (int_pending_q && !ldm_pending_q) begin
      // PC still points at the unfetched word: it is the resume address.
      instr_d       = INT_WORD;
      ldm_d         = 1'b0;
      pcp1_d        = pc;
      int_ack_d     = 1'b1;
      int_pending_d = 1'b0;
      vec_int_d     = 1'b1;
      state_d       = ST_VEC_HI;
    end else begin
      instr_d       = imem_data;
      ldm_d         = ldm_pending_q;
      pcp1_d        = pc + PC_WIDTH'(1);
      ldm_pending_d = !ldm_pending_q && (imem_data[WIDTH-1 -: 5] == OPC_LDM);
      pc_op         = redir_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_VEC_HI;
      vec_int_q     <= 1'b0;
      ldm_pending_q <= 1'b0;
      int_pending_q <= 1'b0;
      instr_q       <= '0;
      ldm_q         <= 1'b0;
      pcp1_q        <= '0;
      int_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      vec_int_q     <= vec_int_d;
      ldm_pending_q <= ldm_pending_d;
      int_pending_q <= int_pending_d;
      instr_q       <= instr_d;
      ldm_q         <= ldm_d;
      pcp1_q        <= pcp1_d;
      int_ack_q     <= int_ack_d;
    end
  end

  assign instruction = instr_q;
  assign ldm_value   = ldm_q;
  assign pc_plus1    = pcp1_q;
  assign int_ack     = int_ack_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// control traffic, compared cycle by cycle against a behavioural model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall, flush, fpe;
  logic [1:0]  pc_sel;
  logic [31:0] pc_jmp, pc_mem;
  logic        interrupt;
  logic [15:0] instruction;
  logic        ldm_value;
  logic [31:0] pc_plus1;
  logic        int_ack;

  logic [15:0] mem [256];

  int npass  = 0;
  int ntotal = 0;

  // model state
  logic [31:0] m_pc;
  int          m_bub;   // vector-load bubbles still to come
  logic [31:0] m_va;
  bit          m_ldm, m_intp;
  logic [15:0] e_instr;
  bit          e_ldm, e_ack, e_valid;
  logic [31:0] e_p1;

  fetch_unit #(
    .WIDTH       (16),
    .PC_WIDTH    (32),
    .RST_VEC_ADDR(0),
    .INT_VEC_ADDR(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .flush          (flush),
    .fetch_pc_enable(fpe),
    .pc_sel         (pc_sel),
    .pc_jmp         (pc_jmp),
    .pc_mem         (pc_mem),
    .interrupt      (interrupt),
    .instruction    (instruction),
    .ldm_value      (ldm_value),
    .pc_plus1       (pc_plus1),
    .int_ack        (int_ack)
  );

  assign imem_data = mem[imem_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model();
    logic [31:0] nxt;
    logic [15:0] w;
    bit          ip;
    nxt   = (pc_sel == 2'b01) ? pc_jmp : (pc_sel == 2'b10) ? pc_mem : m_pc + 32'd1;
    e_ack = 1'b0;
    if (rst) begin
      m_pc = '0; m_bub = 2; m_va = '0; m_ldm = 0; m_intp = 0;
      e_instr = '0; e_ldm = 0; e_p1 = '0; e_valid = 1;
    end else begin
      ip = m_intp | interrupt;
      if (m_bub > 0) begin
        e_instr = '0; e_ldm = 0; e_valid = 0;
        m_bub--;
        if (m_bub == 0) m_pc = {mem[m_va[7:0]], mem[8'(m_va + 32'd1)]};
      end else if (flush) begin
        e_instr = '0; e_ldm = 0; e_valid = 0; m_ldm = 0; m_pc = nxt;
      end else if (stall) begin
        // everything holds
      end else if (!fpe) begin
        e_instr = '0; e_ldm = 0; e_valid = 0;
      end else if (m_intp && !m_ldm) begin
        e_instr = 16'hF800; e_ldm = 0; e_p1 = m_pc; e_valid = 1; e_ack = 1;
        ip = 0; m_bub = 2; m_va = 32'd2;
      end else begin
        w       = mem[m_pc[7:0]];
        e_instr = w; e_ldm = m_ldm; e_p1 = m_pc + 32'd1; e_valid = 1;
        m_ldm   = !m_ldm && (w[15:11] == 5'b10011);
        m_pc    = nxt;
      end
      m_intp = ip;
    end
  endtask

  task automatic step();
    logic [31:0] ea;
    model();
    @(posedge clk);
    #1;
    ea = (m_bub == 2) ? m_va : (m_bub == 1) ? m_va + 32'd1 : m_pc;
    chk("instruction", {16'h0, instruction}, {16'h0, e_instr});
    chk("ldm_value", {31'h0, ldm_value}, {31'h0, e_ldm});
    chk("int_ack", {31'h0, int_ack}, {31'h0, e_ack});
    chk("imem_addr", imem_addr, ea);
    if (e_valid) chk("pc_plus1", pc_plus1, e_p1);
  endtask

  initial begin
    logic [15:0] w;
    int          r;
    rst = 1; flush = 0; stall = 0; fpe = 1; pc_sel = 0;
    pc_jmp = 0; pc_mem = 0; interrupt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0800 + 16'(i);
    mem[0] = 16'h0000; mem[1] = 16'h0010; mem[2] = 16'h0000; mem[3] = 16'h0080;
    mem[8'h10] = 16'h9805; mem[8'h11] = 16'hBEEF; mem[8'h12] = 16'h1234;
    mem[8'h50] = 16'h9801; mem[8'h51] = 16'hCAFE; mem[8'h52] = 16'h2222;
    mem[8'h80] = 16'h3333;

    step(); step();
    chk("reset_instruction", {16'h0, instruction}, 32'h0);
    chk("reset_pc_plus1", pc_plus1, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);

    rst = 0;
    step(); step(); step();
    chk("first_word", {16'h0, instruction}, 32'h9805);
    chk("first_pc_plus1", pc_plus1, 32'h11);
    step();
    chk("ldm_imm", {16'h0, instruction}, 32'hBEEF);
    chk("ldm_imm_flag", {31'h0, ldm_value}, 32'h1);
    step();
    chk("after_imm_flag", {31'h0, ldm_value}, 32'h0);

    flush = 1; pc_sel = 2'b01; pc_jmp = 32'h40;
    step();
    chk("flush_nop", {16'h0, instruction}, 32'h0);
    flush = 0; pc_sel = 2'b00;
    step();
    chk("jmp_target", {16'h0, instruction}, 32'h0840);

    stall = 1;
    step(); step(); step();
    chk("stall_instruction", {16'h0, instruction}, 32'h0840);
    chk("stall_pc_plus1", pc_plus1, 32'h41);
    chk("stall_addr", imem_addr, 32'h41);
    stall = 0;
    step();

    pc_sel = 2'b01; pc_jmp = 32'h50;
    step();
    pc_sel = 2'b00; interrupt = 1;
    step();
    interrupt = 0;
    step();
    chk("int_imm_first", {16'h0, instruction}, 32'hCAFE);
    step();
    chk("int_word", {16'h0, instruction}, 32'hF800);
    chk("int_ack_pulse", {31'h0, int_ack}, 32'h1);
    chk("int_resume_pc", pc_plus1, 32'h52);
    step(); step(); step();
    chk("isr_first", {16'h0, instruction}, 32'h3333);

    pc_sel = 2'b01; pc_jmp = 32'hFFFF_FFFF;
    step();
    pc_sel = 2'b00;
    step();
    chk("wrap_pc_plus1", pc_plus1, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    rst = 1; step(); rst = 0; interrupt = 1;
    step();
    interrupt = 0; rst = 1;
    step();
    chk("vec_lo_rst_addr", imem_addr, 32'h0);
    chk("vec_lo_rst_instr", {16'h0, instruction}, 32'h0);
    rst = 0;
    step(); step(); step();
    chk("restart_first", {16'h0, instruction}, 32'h9805);

    for (int i = 4; i < 256; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 4) == 0) w[15:11] = 5'b10011;
      mem[i] = w;
    end
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 149) == 0);
      interrupt = ($urandom_range(0, 19) == 0);
      r         = $urandom_range(0, 9);
      pc_sel    = (r < 6) ? 2'b00 : 2'($urandom_range(1, 3));
      pc_jmp    = $urandom;
      pc_mem    = $urandom;
      if (m_bub > 0) begin
        flush = 0; stall = 0; fpe = 1;
      end else begin
        flush = ($urandom_range(0, 9) == 0);
        stall = ($urandom_range(0, 5) == 0);
        fpe   = ($urandom_range(0, 9) != 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
